uart_sample_sequencer: RTL and testbench

Sequences the UART byte stream into fixed-width audio samples and paces them to the audio output. Sits between the UART receiver and the DAC/I2S transmitter: assembles little-endian byte groups into BPS-bit samples, buffers them in a FIFO, and releases one sample per sample-rate request. Inter-byte timeout recovers byte alignment, and sticky status flags report overflow and underrun.

---
 rtl/uart_audio_pkg.sv | 16 +
 rtl/sample_fifo.sv | 52 +++++
 rtl/uart_sample_sequencer.sv | 130 +++++++++++++
 tb/tb_uart_sample_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_audio_pkg.sv
// Shared constants and helpers for the UART-to-audio sample path.
package uart_audio_pkg;

  localparam int BYTE_W             = 8;
  localparam int DEF_BPS            = 24;
  localparam int DEF_FIFO_DEPTH     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 10000;

  // Byte-index width for a bps-bit sample; at least 1 bit even for 8-bit samples.
  function automatic int idx_width(input int bps);
    int nb;
    nb = bps / BYTE_W;
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO: push/pop, level count, full/empty; head is read combinationally.
module sample_fifo
  import uart_audio_pkg::*;
#(
  parameter  int W     = DEF_BPS,
  parameter  int DEPTH = DEF_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_push,
  input  logic [W-1:0]     in_data,
  input  logic             in_pop,
  output logic [W-1:0]     out_head,
  output logic [LVL_W-1:0] out_level,
  output logic             out_full,
  output logic             out_empty
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_ok, pop_ok;

  assign out_full  = (level_q == LVL_W'(DEPTH));
  assign out_empty = (level_q == '0);
  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign pop_ok    = in_pop && !out_empty;
  assign push_ok   = in_push && (!out_full || pop_ok);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end
  end

  // NOTE: storage is deliberately not reset; the level gates every read, so stale words are never seen.
  always_ff @(posedge in_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_head  = mem_q[rd_ptr_q];
  assign out_level = level_q;

endmodule

// File: rtl/uart_sample_sequencer.sv
// Assembles little-endian UART bytes into samples, buffers them and releases one per request.
// Optional inter-byte timeout resync is enabled by defining UART_SEQ_TIMEOUT_EN.
module uart_sample_sequencer
  import uart_audio_pkg::*;
#(
  parameter  int BPS            = DEF_BPS,
  parameter  int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int NB             = BPS / BYTE_W,
  localparam int IDX_W          = idx_width(BPS),
  localparam int LVL_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_uart_ready,
  input  logic [BYTE_W-1:0] in_uart_frame,
  input  logic              in_sample_req,
  input  logic              in_status_clr,
  output logic [BPS-1:0]    out_sample,
  output logic              out_sample_valid,
  output logic [LVL_W-1:0]  out_fifo_level,
  output logic              out_overflow,
  output logic              out_underrun,
  output logic              out_resync
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BPS-1:0]   part_q, part_d, word;
  logic [BPS-1:0]   sample_q, head;
  logic             valid_q, overflow_q, underrun_q;
  logic             byte_last, push, pop, fifo_full, fifo_empty, timeout_fire;

  assign byte_last = (idx_q == IDX_W'(NB - 1));
  assign push      = in_uart_ready && byte_last;
  assign pop       = in_sample_req && !fifo_empty;

  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
  always_comb begin
    word = part_q;
    word[BYTE_W*(NB-1) +: BYTE_W] = in_uart_frame;
  end

  always_comb begin
    idx_d  = idx_q;
    part_d = part_q;
    if (in_uart_ready) begin
      if (byte_last) begin
        idx_d = '0;
      end else begin
        part_d[int'(idx_q)*BYTE_W +: BYTE_W] = in_uart_frame;
        idx_d = idx_q + IDX_W'(1);
      end
    end else if (timeout_fire) begin
      idx_d = '0;
    end
  end

`ifdef UART_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resync_q;

  // A byte strobe always takes priority over a timeout firing in the same cycle.
  always_comb begin
    cnt_d        = '0;
    timeout_fire = 1'b0;
    if (!in_uart_ready && idx_q != '0) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) timeout_fire = 1'b1;
      else                                     cnt_d        = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      cnt_q    <= '0;
      resync_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      resync_q <= timeout_fire;
    end
  end

  assign out_resync = resync_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_fire   = 1'b0;
  assign out_resync     = 1'b0;
`endif

  sample_fifo #(
    .W     (BPS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .in_push   (push),
    .in_data   (word),
    .in_pop    (pop),
    .out_head  (head),
    .out_level (out_fifo_level),
    .out_full  (fifo_full),
    .out_empty (fifo_empty)
  );

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      idx_q      <= '0;
      part_q     <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      part_q     <= part_d;
      valid_q    <= pop;
      if (pop) sample_q <= head;
      // Sticky flags: a new set event in the clearing cycle wins over the clear.
      overflow_q <= (overflow_q && !in_status_clr) || (push && fifo_full && !pop);
      underrun_q <= (underrun_q && !in_status_clr) || (in_sample_req && fifo_empty);
    end
  end

  assign out_sample       = sample_q;
  assign out_sample_valid = valid_q;
  assign out_overflow     = overflow_q;
  assign out_underrun     = underrun_q;

endmodule

// File: tb/tb_uart_sample_sequencer.sv
// Self-checking bench: directed scenarios plus a randomized run against a queue-based model.
module tb_uart_sample_sequencer;

  localparam int BPS     = 24;
  localparam int NB      = BPS / 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 100;
`ifdef UART_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           in_rst = 1'b1, in_uart_ready = 1'b0, in_sample_req = 1'b0, in_status_clr = 1'b0;
  logic [7:0]     in_uart_frame = '0;
  logic [BPS-1:0] out_sample;
  logic           out_sample_valid, out_overflow, out_underrun, out_resync;
  logic [2:0]     out_fifo_level;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int unsigned fq[$];
  logic [7:0]  pend[$];
  int          idle;
  bit          m_ovf, m_und, m_valid, m_resync;
  int unsigned m_sample;

  always #5 clk = ~clk;

  uart_sample_sequencer #(
    .BPS(BPS), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .in_clk           (clk),
    .in_rst           (in_rst),
    .in_uart_ready    (in_uart_ready),
    .in_uart_frame    (in_uart_frame),
    .in_sample_req    (in_sample_req),
    .in_status_clr    (in_status_clr),
    .out_sample       (out_sample),
    .out_sample_valid (out_sample_valid),
    .out_fifo_level   (out_fifo_level),
    .out_overflow     (out_overflow),
    .out_underrun     (out_underrun),
    .out_resync       (out_resync)
  );

  // Drives one clock of inputs, advances the model, and returns 1ns after the edge.
  task automatic step(input bit rst, input bit rdy, input logic [7:0] b, input bit req, input bit clr);
    bit          pop_ok, push_w, fire;
    int unsigned w;
    in_rst = rst; in_uart_ready = rdy; in_uart_frame = b; in_sample_req = req; in_status_clr = clr;
    if (rst) begin
      fq.delete(); pend.delete(); idle = 0;
      m_ovf = 0; m_und = 0; m_valid = 0; m_resync = 0; m_sample = 0;
    end else begin
      fire = 0; push_w = 0; w = 0;
      if (rdy) begin
        pend.push_back(b);
        idle = 0;
        if (pend.size() == NB) begin
          foreach (pend[k]) w |= 32'(pend[k]) << (8 * k);
          pend.delete();
          push_w = 1;
        end
      end else if (TO_EN && pend.size() != 0) begin
        idle++;
        if (idle == TIMEOUT) begin
          pend.delete(); idle = 0; fire = 1;
        end
      end else begin
        idle = 0;
      end
      pop_ok = req && (fq.size() > 0);
      m_und  = (m_und && !clr) || (req && fq.size() == 0);
      m_ovf  = (m_ovf && !clr) || (push_w && fq.size() == DEPTH && !pop_ok);
      if (pop_ok) m_sample = fq.pop_front();
      if (push_w && fq.size() < DEPTH) fq.push_back(w);
      m_valid  = pop_ok;
      m_resync = fire;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int k = 0; k < NB; k++) step(0, 1, w[8*k +: 8], 0, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    total++; if (out_sample !== 24'h0) begin bad++; $display("FAIL reset_sample got=%h exp=0", out_sample); end
    total++; if (out_sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_sample_valid); end
    total++; if (out_fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", out_fifo_level); end
    total++; if (out_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", out_overflow); end
    total++; if (out_underrun !== 1'b0) begin bad++; $display("FAIL reset_und got=%b exp=0", out_underrun); end
    total++; if (out_resync !== 1'b0) begin bad++; $display("FAIL reset_resync got=%b exp=0", out_resync); end
    step(0, 0, 8'h00, 0, 0);
  endtask

  task automatic test_basic();
    step(0, 1, 8'h56, 0, 0);
    step(0, 1, 8'h34, 0, 0);
    total++; if (out_fifo_level !== 3'd0) begin bad++; $display("FAIL basic_partial_level got=%0d exp=0", out_fifo_level); end
    step(0, 1, 8'h12, 0, 0);
    total++; if (out_fifo_level !== 3'd1) begin bad++; $display("FAIL basic_level1 got=%0d exp=1", out_fifo_level); end
    step(0, 0, 8'h00, 1, 0);
    total++; if (out_fifo_level !== 3'd0) begin bad++; $display("FAIL basic_level0 got=%0d exp=0", out_fifo_level); end
    total++; if (out_sample !== 24'h123456) begin bad++; $display("FAIL basic_sample got=%h exp=123456", out_sample); end
    total++; if (out_sample_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_sample_valid); end
    step(0, 0, 8'h00, 0, 0);
    total++; if (out_sample_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%b exp=0", out_sample_valid); end
  endtask

  task automatic test_overflow();
    logic [23:0] s [5];
    foreach (s[i]) begin
      s[i] = 24'($urandom);
      send_word(s[i]);
    end
    total++; if (out_fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", out_fifo_level); end
    total++; if (out_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", out_overflow); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'h00, 1, 0);
      total++; if (out_sample !== s[i] || out_sample_valid !== 1'b1) begin
        bad++; $display("FAIL ovf_pop%0d got=%h/%b exp=%h/1", i, out_sample, out_sample_valid, s[i]);
      end
    end
    step(0, 0, 8'h00, 0, 1);
    total++; if (out_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", out_overflow); end
  endtask

  task automatic test_underrun();
    send_word(24'hABCDEF);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    total++; if (out_sample !== 24'hABCDEF) begin bad++; $display("FAIL und_hold got=%h exp=abcdef", out_sample); end
    total++; if (out_sample_valid !== 1'b0) begin bad++; $display("FAIL und_novalid got=%b exp=0", out_sample_valid); end
    total++; if (out_underrun !== 1'b1) begin bad++; $display("FAIL und_flag got=%b exp=1", out_underrun); end
    step(0, 0, 8'h00, 1, 1);
    total++; if (out_underrun !== 1'b1) begin bad++; $display("FAIL und_set_wins got=%b exp=1", out_underrun); end
    step(0, 0, 8'h00, 0, 1);
    total++; if (out_underrun !== 1'b0) begin bad++; $display("FAIL und_clear got=%b exp=0", out_underrun); end
  endtask

  task automatic test_timeout();
    int          pulses;
    logic [23:0] exp_w;
    pulses = 0;
    step(1, 0, 8'h00, 0, 0);
    step(0, 1, 8'h11, 0, 0); pulses += int'(out_resync);
    step(0, 1, 8'h22, 0, 0); pulses += int'(out_resync);
    for (int i = 0; i < 110; i++) begin step(0, 0, 8'h00, 0, 0); pulses += int'(out_resync); end
    step(0, 1, 8'h33, 0, 0); pulses += int'(out_resync);
    step(0, 1, 8'h44, 0, 0); pulses += int'(out_resync);
    step(0, 1, 8'h55, 0, 0); pulses += int'(out_resync);
    total++; if (pulses !== (TO_EN ? 1 : 0)) begin bad++; $display("FAIL to_pulses got=%0d exp=%0d", pulses, TO_EN ? 1 : 0); end
    step(0, 0, 8'h00, 1, 0);
    exp_w = TO_EN ? 24'h554433 : 24'h332211;
    total++; if (out_sample !== exp_w) begin bad++; $display("FAIL to_sample got=%h exp=%h", out_sample, exp_w); end
    // Short idle never resyncs
    step(1, 0, 8'h00, 0, 0);
    pulses = 0;
    step(0, 1, 8'h11, 0, 0);
    step(0, 1, 8'h22, 0, 0);
    for (int i = 0; i < 50; i++) begin step(0, 0, 8'h00, 0, 0); pulses += int'(out_resync); end
    step(0, 1, 8'h33, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    total++; if (pulses !== 0 || out_sample !== 24'h332211) begin
      bad++; $display("FAIL to_short got=%0d/%h exp=0/332211", pulses, out_sample);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0, 8'h00, 0, 0);
    send_word(24'h5A5A5A);
    step(0, 0, 8'h00, 1, 0);
    send_word(24'h777777);
    step(0, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 1, 0);
    step(0, 1, 8'hAA, 0, 0);
    step(0, 1, 8'hBB, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    total++; if ({out_sample, out_sample_valid, out_fifo_level, out_overflow, out_underrun, out_resync} !== '0) begin
      bad++; $display("FAIL rstmid_outputs got=%h/%b/%0d/%b/%b/%b exp=all zero",
                      out_sample, out_sample_valid, out_fifo_level, out_overflow, out_underrun, out_resync);
    end
    step(0, 1, 8'h01, 0, 0);
    step(0, 1, 8'h02, 0, 0);
    step(0, 1, 8'h03, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    total++; if (out_sample !== 24'h030201) begin bad++; $display("FAIL rstmid_sample got=%h exp=030201", out_sample); end
  endtask

  task automatic test_simultaneous();
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) send_word(24'h100000 + 24'(i));
    step(0, 1, 8'hEE, 0, 0);
    step(0, 1, 8'hDD, 0, 0);
    step(0, 1, 8'hCC, 1, 0);
    total++; if (out_fifo_level !== 3'd4 || out_overflow !== 1'b0) begin
      bad++; $display("FAIL simul_full got=%0d/%b exp=4/0", out_fifo_level, out_overflow);
    end
    total++; if (out_sample !== 24'h100000 || out_sample_valid !== 1'b1) begin
      bad++; $display("FAIL simul_full_pop got=%h/%b exp=100000/1", out_sample, out_sample_valid);
    end
    step(1, 0, 8'h00, 0, 0);
    step(0, 1, 8'h01, 0, 0);
    step(0, 1, 8'h02, 0, 0);
    step(0, 1, 8'h03, 1, 0);
    total++; if (out_fifo_level !== 3'd1 || out_underrun !== 1'b1 || out_sample_valid !== 1'b0) begin
      bad++; $display("FAIL simul_empty got=%0d/%b/%b exp=1/1/0", out_fifo_level, out_underrun, out_sample_valid);
    end
  endtask

  task automatic test_random();
    int gap;
    bit rdy, req, clr;
    gap = 0;
    step(1, 0, 8'h00, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      if (gap > 0) gap--;
      else if ($urandom_range(0, 199) == 0) gap = $urandom_range(95, 105);
      rdy = (gap == 0) && ($urandom_range(0, 1) == 1);
      req = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step(0, rdy, 8'($urandom), req, clr);
      total++;
      if (out_sample !== 24'(m_sample) || out_sample_valid !== m_valid || out_fifo_level !== 3'(fq.size()) ||
          out_overflow !== m_ovf || out_underrun !== m_und || out_resync !== m_resync) begin
        bad++;
        $display("FAIL rand_c%0d got=%h/%b/%0d/%b/%b/%b exp=%h/%b/%0d/%b/%b/%b", c,
                 out_sample, out_sample_valid, out_fifo_level, out_overflow, out_underrun, out_resync,
                 24'(m_sample), m_valid, fq.size(), m_ovf, m_und, m_resync);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underrun();
    test_timeout();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
